eis_unit: RTL and testbench
===========================

EIS_UNIT -- requirements
Module: eis_unit

Interface
REQ-001 SHALL have parameter W, default 16, meaning data word width (even, >=8).
REQ-002 SHALL have parameter CW, default clog2(W)+2, meaning signed shift-count field width.
REQ-003 SHALL have ports: clk in 1 system clock; reset_n in 1 reset; ce in 1 clock enable.
REQ-004 SHALL have ports: start in 1 request; abort in 1 cancel; op in 2 (00 MUL, 01 DIV, 10 ASH, 11 ASHC).
REQ-005 SHALL have ports: src in W (multiplier/divisor/count); reg_hi in W (Rn); reg_lo in W (Rn|1).
REQ-006 SHALL have ports: busy out 1; done out 1; res_hi out W; res_lo out W; flags out 4 {N,Z,V,C}.
REQ-007 SHALL use one clock, clk; reset_n SHALL be asynchronous, active-low.

Function
REQ-008 SHALL implement FSM IDLE, RUN, DONE; state and counters SHALL advance only on clk edges with ce=1.
REQ-009 With ce=0, all state, outputs and counters SHALL hold.
REQ-010 start SHALL be accepted in IDLE or DONE: latch op, src, reg_hi, reg_lo; go RUN (or DONE for 1-cycle cases).
REQ-011 start during RUN SHALL be ignored.
REQ-012 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE, for one ce-cycle, then IDLE.
REQ-013 abort=1 in RUN SHALL return to IDLE next ce-cycle with no done; res/flags SHALL keep prior values.
REQ-014 abort and start in the same cycle SHALL resolve to abort.
REQ-015 res_hi, res_lo, flags SHALL update only on entering DONE and hold until the next DONE.
REQ-016 MUL: signed reg_hi x src to 2W bits, radix-2 iterative, W RUN cycles; done at start+W+1.
REQ-017 MUL flags: N=product sign; Z=product==0; V=0; C=1 iff res_hi is not the sign extension of res_lo.
REQ-018 DIV: signed {reg_hi,reg_lo} / src, W iterations; quotient->res_hi; remainder (dividend's sign)->res_lo; done at start+W+1.
REQ-019 DIV flags: N, Z from quotient; V=0; C=0.
REQ-020 DIV src==0: 1-cycle DONE; res=latched reg_hi/reg_lo; V=1, C=1.
REQ-021 DIV quotient outside W-bit signed range: res=latched inputs; V=1, C=0; early detection permitted, done no later than start+W+1.
REQ-022 ASH: count n=src[CW-1:0] signed; n>0 left, n<0 arithmetic right on reg_hi; one bit per RUN cycle; done at start+|n|+1; res_lo=reg_lo.
REQ-023 ASHC: same as ASH on 2W-bit {reg_hi,reg_lo}.
REQ-024 ASH/ASHC flags: N, Z on result; C=last bit shifted out; V=1 if sign bit changed at any step.
REQ-025 ASH/ASHC n=0: 1-cycle DONE; result unchanged; V=0, C=0.
REQ-026 Iteration counter width SHALL cover max(W, 2^(CW-1)) without wrap.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, res_hi=0, res_lo=0, flags=0, counters=0, including mid-RUN.
REQ-028 After reset release, the first accepted start SHALL behave identically to any later one.

Structure
REQ-029 Shared header eis_pkg SHALL hold op encodings, flag bit indices and FSM state encodings.
REQ-030 Sub-module eis_addsub (W+1-bit add/subtract with carry out) SHALL be shared by MUL and DIV iterations.
REQ-031 Shifting SHALL reuse the accumulator registers; no barrel shifter.

Verification (W=16)
REQ-032 MUL reg_hi=0177773, src=3 -> done at cycle 17; res_hi=0177777, res_lo=0177761; NZVC=1000.
REQ-033 MUL reg_hi=040000, src=4 -> res_hi=1, res_lo=0; C=1, N=0.
REQ-034 DIV {0,7}/2 -> res_hi=3, res_lo=1, NZVC=0000, done at 17; DIV src=0 -> done next cycle, V=1, C=1, res unchanged.
REQ-035 DIV {1,0}/1 -> V=1, C=0, res_hi=1, res_lo=0.
REQ-036 ASH reg_hi=040000, src=1 -> 0100000, N=1, V=1, C=0, done at 2; ASH reg_hi=0100001, src=077 -> 0140000, C=1.
REQ-037 abort at RUN cycle 5 of MUL -> busy=0 next cycle, no done; reset_n=0 mid-DIV -> all outputs 0 asynchronously; ce=0 for 3 cycles mid-MUL -> done delayed exactly 3 cycles.

Source files
------------

// File: rtl/eis_pkg.sv
// Shared encodings for the extended-arithmetic unit: opcodes, flag bit
// positions, FSM states, and a flag-packing helper.
package eis_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_DIV  = 2'b01,
      OP_ASH  = 2'b10,
      OP_ASHC = 2'b11
   } eis_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } eis_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic v, input logic c);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      return f;
   endfunction

endpackage

// File: rtl/eis_addsub.sv
// (W+1)-bit adder/subtractor with carry out, shared by the MUL and DIV iteration steps.
module eis_addsub #(
   parameter int W = 16
) (
   input  logic [W:0] a,
   input  logic [W:0] b,
   input  logic       sub,
   output logic [W:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(W + 1){1'b0}}, sub};

endmodule

// File: rtl/eis_unit.sv
// Iterative MUL / DIV / ASH / ASHC unit: one bit per ce-cycle, sharing one adder
// and one accumulator pair for all operations.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | iterating; cnt counts remaining steps down to 1
//   DONE    | results valid, done=1 for one ce-cycle
module eis_unit
   import eis_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = $clog2(W) + 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ce,
   input  logic         start,
   input  logic         abort,
   input  logic [1:0]   op,
   input  logic [W-1:0] src,
   input  logic [W-1:0] reg_hi,
   input  logic [W-1:0] reg_lo,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] res_hi,
   output logic [W-1:0] res_lo,
   output logic [3:0]   flags
);

   localparam int CNTW = ($clog2(W + 1) > CW) ? $clog2(W + 1) : CW;
   localparam logic [CNTW-1:0] CNT_W   = CNTW'(W);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   eis_state_e      state;
   eis_op_e         op_q;
   logic [W:0]      acc_hi;
   logic [W-1:0]    acc_lo, opnd, in_hi, in_lo;
   logic            q_1, c_acc, v_acc, neg_q, neg_r, shl;
   logic [CNTW-1:0] cnt;

   logic [W:0]      hi_nx, rem_sh, as_a, as_b, as_sum, mul_acc;
   logic [W-1:0]    lo_nx, fin_hi, fin_lo, dvs_mag;
   logic            q1_nx, c_nx, v_nx, as_sub, as_cout, div_ovf_late, div_ovf_early;
   logic [3:0]      fin_flags;
   logic [2*W-1:0]  dvd_mag;
   logic [CW-1:0]   n_mag;

   // Start-time operand conditioning: magnitudes for DIV, |count| for shifts
   assign dvd_mag = reg_hi[W-1] ? (~{reg_hi, reg_lo} + (2*W)'(1)) : {reg_hi, reg_lo};
   assign dvs_mag = src[W-1] ? (~src + W'(1)) : src;
   assign n_mag   = src[CW-1] ? (~src[CW-1:0] + CW'(1)) : src[CW-1:0];
   // Unsigned quotient fits W bits only when the dividend's high half is below the divisor
   assign div_ovf_early = (dvd_mag[2*W-1:W] >= dvs_mag);

   assign rem_sh  = {acc_hi[W-1:0], acc_lo[W-1]};
   assign as_a    = (op_q == OP_DIV) ? rem_sh : acc_hi;
   assign as_b    = (op_q == OP_DIV) ? {1'b0, opnd} : {opnd[W-1], opnd};
   assign as_sub  = (op_q == OP_DIV) | acc_lo[0];
   assign mul_acc = (acc_lo[0] ^ q_1) ? as_sum : acc_hi;

   eis_addsub #(.W(W)) u_addsub (
      .a    (as_a),
      .b    (as_b),
      .sub  (as_sub),
      .sum  (as_sum),
      .cout (as_cout)
   );

   always_comb begin
      hi_nx = acc_hi;
      lo_nx = acc_lo;
      q1_nx = q_1;
      c_nx  = c_acc;
      v_nx  = v_acc;
      case (op_q)
         OP_MUL: begin
            // Booth radix-2 step followed by arithmetic right shift of {acc_hi, acc_lo, q_1}
            hi_nx = {mul_acc[W], mul_acc[W:1]};
            lo_nx = {mul_acc[0], acc_lo[W-1:1]};
            q1_nx = acc_lo[0];
         end
         OP_DIV: begin
            hi_nx = as_cout ? as_sum : rem_sh;
            lo_nx = {acc_lo[W-2:0], as_cout};
         end
         default: begin
            if (shl) begin
               hi_nx = {acc_hi[W-2], acc_hi[W-2:0], (op_q == OP_ASHC) ? acc_lo[W-1] : 1'b0};
               if (op_q == OP_ASHC) lo_nx = {acc_lo[W-2:0], 1'b0};
               c_nx  = acc_hi[W-1];
               v_nx  = v_acc | (acc_hi[W-1] ^ acc_hi[W-2]);
            end else begin
               hi_nx = {acc_hi[W-1], acc_hi[W-1], acc_hi[W-1:1]};
               if (op_q == OP_ASHC) begin
                  lo_nx = {acc_hi[0], acc_lo[W-1:1]};
                  c_nx  = acc_lo[0];
               end else begin
                  c_nx  = acc_hi[0];
               end
            end
         end
      endcase
   end

   assign div_ovf_late = neg_q ? (lo_nx[W-1] & (|lo_nx[W-2:0])) : lo_nx[W-1];

   always_comb begin
      fin_hi    = hi_nx[W-1:0];
      fin_lo    = lo_nx;
      fin_flags = '0;
      case (op_q)
         OP_MUL: fin_flags = pack_flags(hi_nx[W-1], ~|{hi_nx[W-1:0], lo_nx}, 1'b0,
                                        hi_nx[W-1:0] != {W{lo_nx[W-1]}});
         OP_DIV: begin
            if (div_ovf_late) begin
               fin_hi    = in_hi;
               fin_lo    = in_lo;
               fin_flags = pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
               fin_hi    = neg_q ? (~lo_nx + W'(1)) : lo_nx;
               fin_lo    = neg_r ? (~hi_nx[W-1:0] + W'(1)) : hi_nx[W-1:0];
               fin_flags = pack_flags(fin_hi[W-1], fin_hi == '0, 1'b0, 1'b0);
            end
         end
         OP_ASH:  fin_flags = pack_flags(fin_hi[W-1], fin_hi == '0, v_nx, c_nx);
         default: fin_flags = pack_flags(fin_hi[W-1], {fin_hi, fin_lo} == '0, v_nx, c_nx);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
         flags  <= '0;
         op_q   <= OP_MUL;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         in_hi  <= '0;
         in_lo  <= '0;
         q_1    <= 1'b0;
         c_acc  <= 1'b0;
         v_acc  <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         shl    <= 1'b0;
         cnt    <= '0;
      end else if (ce) begin
         case (state)
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  acc_hi <= hi_nx;
                  acc_lo <= lo_nx;
                  q_1    <= q1_nx;
                  c_acc  <= c_nx;
                  v_acc  <= v_nx;
                  cnt    <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state  <= ST_DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     res_hi <= fin_hi;
                     res_lo <= fin_lo;
                     flags  <= fin_flags;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               if (start && !abort) begin
                  op_q  <= eis_op_e'(op);
                  in_hi <= reg_hi;
                  in_lo <= reg_lo;
                  q_1   <= 1'b0;
                  c_acc <= 1'b0;
                  v_acc <= 1'b0;
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  case (eis_op_e'(op))
                     OP_MUL: begin
                        acc_hi <= '0;
                        acc_lo <= src;
                        opnd   <= reg_hi;
                        cnt    <= CNT_W;
                     end
                     OP_DIV: begin
                        acc_hi <= {1'b0, dvd_mag[2*W-1:W]};
                        acc_lo <= dvd_mag[W-1:0];
                        opnd   <= dvs_mag;
                        neg_q  <= reg_hi[W-1] ^ src[W-1];
                        neg_r  <= reg_hi[W-1];
                        cnt    <= CNT_W;
                        if (src == '0 || div_ovf_early) begin
                           state  <= ST_DONE;
                           busy   <= 1'b0;
                           done   <= 1'b1;
                           cnt    <= '0;
                           res_hi <= reg_hi;
                           res_lo <= reg_lo;
                           flags  <= pack_flags(1'b0, 1'b0, 1'b1, src == '0);
                        end
                     end
                     default: begin
                        acc_hi <= {reg_hi[W-1], reg_hi};
                        acc_lo <= reg_lo;
                        opnd   <= src;
                        shl    <= ~src[CW-1];
                        cnt    <= CNTW'(n_mag);
                        if (n_mag == '0) begin
                           state  <= ST_DONE;
                           busy   <= 1'b0;
                           done   <= 1'b1;
                           res_hi <= reg_hi;
                           res_lo <= reg_lo;
                           flags  <= pack_flags(reg_hi[W-1],
                                                (op == OP_ASHC) ? ({reg_hi, reg_lo} == '0)
                                                                : (reg_hi == '0),
                                                1'b0, 1'b0);
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eis_unit.sv
// Scoreboard bench for eis_unit: directed operations push expected results,
// a negedge monitor pops and compares on each rising done.
module tb_eis_unit;
   import eis_pkg::*;

   localparam int W = 16;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b0;
   logic         ce      = 1'b1;
   logic         start   = 1'b0;
   logic         abort   = 1'b0;
   logic [1:0]   op      = 2'b00;
   logic [W-1:0] src     = '0;
   logic [W-1:0] reg_hi  = '0;
   logic [W-1:0] reg_lo  = '0;
   logic         busy, done;
   logic [W-1:0] res_hi, res_lo;
   logic [3:0]   flags;

   int   cyc    = 0;
   int   passed = 0;
   int   total  = 0;
   logic done_d = 1'b0;

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic [3:0]   fl;
      logic [3:0]   fm;
      int           lat;
      int           t0;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   eis_unit #(.W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .start   (start),
      .abort   (abort),
      .op      (op),
      .src     (src),
      .reg_hi  (reg_hi),
      .reg_lo  (reg_lo),
      .busy    (busy),
      .done    (done),
      .res_hi  (res_hi),
      .res_lo  (res_lo),
      .flags   (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      else passed++;
   endfunction

   task automatic issue(input string nm, input logic [1:0] o, input logic [W-1:0] s,
                        input logic [W-1:0] h, input logic [W-1:0] l,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic [3:0] ef, input logic [3:0] em, input int lat);
      exp_t e;
      @(negedge clk);
      op = o; src = s; reg_hi = h; reg_lo = l; start = 1'b1;
      e.name = nm; e.hi = eh; e.lo = el; e.fl = ef; e.fm = em; e.lat = lat; e.t0 = cyc;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         total++;
         $display("FAIL %s_timeout: %0d results pending, required 0", nm, sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: compare on each rising done
   initial begin
      forever begin
         @(negedge clk);
         if (done && !done_d) begin
            if (sbq.size() == 0) begin
               total++;
               $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
               mon_e = sbq.pop_front();
               chk({mon_e.name, "_hi"}, 32'(res_hi), 32'(mon_e.hi));
               chk({mon_e.name, "_lo"}, 32'(res_lo), 32'(mon_e.lo));
               chk({mon_e.name, "_flags"}, 32'(flags & mon_e.fm), 32'(mon_e.fl & mon_e.fm));
               if (mon_e.lat > 0)
                  chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
         end
         done_d = done;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_busy_done", 32'({busy, done}), 32'd0);
      chk("rst_res", {res_hi, res_lo}, 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue("mul_m5x3", 2'b00, 16'h0003, 16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFF1, 4'b1000, 4'hF, 17);
      wait_drain("mul_m5x3");
      issue("mul_4000x4", 2'b00, 16'h0004, 16'h4000, 16'h0000, 16'h0001, 16'h0000, 4'b0001, 4'hF, 17);
      wait_drain("mul_4000x4");

      // abort at RUN cycle 5: no done, results held
      @(negedge clk);
      op = 2'b00; src = 16'h0007; reg_hi = 16'h0009; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy_after", 32'({busy, done}), 32'd0);
      repeat (20) @(negedge clk);
      chk("abort_res_held", {res_hi, res_lo}, 32'h0001_0000);
      chk("abort_flags_held", 32'(flags), 32'h1);

      // start together with abort is dropped
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);

      issue("mul_0x7", 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 4'hF, 17);
      wait_drain("mul_0x7");
      issue("mul_min_sq", 2'b00, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 16'h0000, 4'b0001, 4'hF, 17);
      wait_drain("mul_min_sq");

      issue("div_7by2", 2'b01, 16'h0002, 16'h0000, 16'h0007, 16'h0003, 16'h0001, 4'b0000, 4'hF, 17);
      wait_drain("div_7by2");
      issue("div_by0", 2'b01, 16'h0000, 16'h1234, 16'h5678, 16'h1234, 16'h5678, 4'b0011, 4'b0011, 1);
      wait_drain("div_by0");
      issue("div_ovf_early", 2'b01, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 4'b0010, 4'b0011, 0);
      wait_drain("div_ovf_early");
      issue("div_m7by2", 2'b01, 16'h0002, 16'hFFFF, 16'hFFF9, 16'hFFFD, 16'hFFFF, 4'b1000, 4'hF, 17);
      wait_drain("div_m7by2");
      issue("div_ovf_late", 2'b01, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 4'b0010, 4'b0011, 0);
      wait_drain("div_ovf_late");
      issue("div_minq", 2'b01, 16'h0001, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000, 4'b1000, 4'hF, 17);
      wait_drain("div_minq");

      issue("ash_l1", 2'b10, 16'h0001, 16'h4000, 16'h00AA, 16'h8000, 16'h00AA, 4'b1010, 4'hF, 2);
      wait_drain("ash_l1");
      issue("ash_r1", 2'b10, 16'h003F, 16'h8001, 16'h0055, 16'hC000, 16'h0055, 4'b1001, 4'hF, 2);
      wait_drain("ash_r1");
      issue("ash_n0", 2'b10, 16'h0040, 16'h1234, 16'h0042, 16'h1234, 16'h0042, 4'b0000, 4'hF, 1);
      wait_drain("ash_n0");
      issue("ash_l31", 2'b10, 16'h001F, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b0110, 4'hF, 32);
      wait_drain("ash_l31");
      issue("ash_r32", 2'b10, 16'h0020, 16'h8000, 16'h0011, 16'hFFFF, 16'h0011, 4'b1001, 4'hF, 33);
      wait_drain("ash_r32");
      issue("ashc_l2", 2'b11, 16'h0002, 16'h0001, 16'h8000, 16'h0006, 16'h0000, 4'b0000, 4'hF, 3);
      wait_drain("ashc_l2");
      issue("ashc_r3", 2'b11, 16'h003D, 16'h8000, 16'h0005, 16'hF000, 16'h0000, 4'b1001, 4'hF, 4);
      wait_drain("ashc_r3");

      // start while RUN is ignored
      issue("mul_ign_start", 2'b00, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h000F, 4'b0000, 4'hF, 17);
      repeat (2) @(negedge clk);
      op = 2'b01; src = 16'h0001; reg_hi = 16'h0000; reg_lo = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain("mul_ign_start");

      // ce low for 3 cycles delays done by exactly 3
      issue("mul_ce_pause", 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 4'hF, 20);
      repeat (4) @(negedge clk);
      ce = 1'b0;
      repeat (3) @(negedge clk);
      ce = 1'b1;
      wait_drain("mul_ce_pause");

      // asynchronous reset in the middle of a DIV
      @(negedge clk);
      op = 2'b01; src = 16'h0003; reg_hi = 16'h0000; reg_lo = 16'h0100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("div_busy_pre_reset", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrun_rst_busy_done", 32'({busy, done}), 32'd0);
      chk("midrun_rst_res", {res_hi, res_lo}, 32'd0);
      chk("midrun_rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue("mul_after_rst", 2'b00, 16'h0003, 16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFF1, 4'b1000, 4'hF, 17);
      wait_drain("mul_after_rst");
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
